// File: rtl/psram_access_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller command port between a frame writer and a frame reader.
// Optional grant watchdog compiled in with `define PSRAM_ARB_WATCHDOG_EN.
module psram_access_arbiter #(
  parameter int GAP_CYCLES      = 2,
  parameter int READ_BEATS      = 8,
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init_done,
  input  logic        wr_rq,
  output logic        wr_ack,
  input  logic        wr_mem_en,
  input  logic [20:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_rq,
  output logic        rd_ack,
  input  logic        rd_mem_en,
  input  logic [20:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        mem_cmd,
  output logic        mem_cmd_en,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_data_valid,
  output logic        arb_timeout,
  output logic [2:0]  dbg_state
);

  // Handshake: a requester holds rq high as a level; ack is high for every cycle it owns
  // the port; commands are one-cycle *_mem_en strobes accepted only from the current owner.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT_WR = 3'd1,
    S_GRANT_RD = 3'd2,
    S_DRAIN    = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam logic [4:0] BEATS    = 5'(READ_BEATS);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic       OWN_RD   = 1'b0;
  localparam logic       OWN_WR   = 1'b1;

  state_t      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [4:0]  beat_q, beat_d;
  logic        last_q, last_d;
  logic        cmd_en_q, cmd_en_d;
  logic        cmd_q, cmd_d;
  logic [20:0] addr_q, addr_d;

  logic wr_cmd_ok, rd_cmd_ok, owner_cmd, in_grant;
  logic wr_eff, rd_eff, wd_fire;

  assign in_grant  = (state_q == S_GRANT_WR) || (state_q == S_GRANT_RD);
  assign wr_cmd_ok = (state_q == S_GRANT_WR) && wr_mem_en;
  // A second read while beats are still outstanding is dropped entirely.
  assign rd_cmd_ok = (state_q == S_GRANT_RD) && rd_mem_en && (beat_q == 5'd0);
  assign owner_cmd = wr_cmd_ok || ((state_q == S_GRANT_RD) && rd_mem_en);

`ifdef PSRAM_ARB_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        wr_blk_q, wr_blk_d, rd_blk_q, rd_blk_d;
  logic        tmo_q, tmo_d;

  assign wd_fire = in_grant && !owner_cmd && (wd_q == 16'(WATCHDOG_CYCLES - 1));
  // A revoked requester stays blocked until its rq has been seen low once.
  assign wr_eff  = wr_rq && !wr_blk_q;
  assign rd_eff  = rd_rq && !rd_blk_q;

  always_comb begin
    wd_d     = (in_grant && !owner_cmd && !wd_fire) ? wd_q + 16'd1 : 16'd0;
    tmo_d    = tmo_q || wd_fire;
    wr_blk_d = ((state_q == S_GRANT_WR) && wd_fire && wr_rq) ? 1'b1 : (wr_rq && wr_blk_q);
    rd_blk_d = ((state_q == S_GRANT_RD) && wd_fire && rd_rq) ? 1'b1 : (rd_rq && rd_blk_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q     <= 16'd0;
      tmo_q    <= 1'b0;
      wr_blk_q <= 1'b0;
      rd_blk_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
      wr_blk_q <= wr_blk_d;
      rd_blk_q <= rd_blk_d;
    end
  end

  assign arb_timeout = tmo_q;
`else
  logic unused_wd;
  assign unused_wd   = ^WATCHDOG_CYCLES;
  assign wd_fire     = 1'b0;
  assign wr_eff      = wr_rq;
  assign rd_eff      = rd_rq;
  assign arb_timeout = 1'b0;
`endif

  // Beat counter and registered command path.
  always_comb begin
    beat_d = beat_q;
    if (rd_cmd_ok)
      beat_d = BEATS;
    else if (mem_rd_data_valid && (beat_q != 5'd0))
      beat_d = beat_q - 5'd1;

    cmd_en_d = wr_cmd_ok || rd_cmd_ok;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    if (wr_cmd_ok) begin
      cmd_d  = 1'b1;
      addr_d = wr_addr;
    end else if (rd_cmd_ok) begin
      cmd_d  = 1'b0;
      addr_d = rd_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = 4'd0;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (mem_init_done) begin
          if (wr_eff && rd_eff) begin
            if (last_q == OWN_RD) begin
              state_d = S_GRANT_WR;
              last_d  = OWN_WR;
            end else begin
              state_d = S_GRANT_RD;
              last_d  = OWN_RD;
            end
          end else if (wr_eff) begin
            state_d = S_GRANT_WR;
            last_d  = OWN_WR;
          end else if (rd_eff) begin
            state_d = S_GRANT_RD;
            last_d  = OWN_RD;
          end
        end
      end
      S_GRANT_WR: begin
        if (!wr_rq || wd_fire)
          state_d = (beat_d != 5'd0) ? S_DRAIN : S_GAP;
      end
      S_GRANT_RD: begin
        // Uses beat_d so a read issued on the release edge still drains.
        if (!rd_rq || wd_fire)
          state_d = (beat_d != 5'd0) ? S_DRAIN : S_GAP;
      end
      S_DRAIN: begin
        if (beat_d == 5'd0)
          state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST)
          state_d = S_IDLE;
        else
          gap_d = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gap_q    <= 4'd0;
      beat_q   <= 5'd0;
      last_q   <= OWN_RD;
      cmd_en_q <= 1'b0;
      cmd_q    <= 1'b0;
      addr_q   <= 21'd0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      cmd_en_q <= cmd_en_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
    end
  end

  assign wr_ack        = (state_q == S_GRANT_WR);
  assign rd_ack        = (state_q == S_GRANT_RD);
  assign mem_cmd_en    = cmd_en_q;
  assign mem_cmd       = cmd_q;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = (state_q == S_GRANT_WR) ? wr_data : 32'd0;
  assign rd_data       = mem_rd_data;
  assign rd_data_valid = mem_rd_data_valid && ((state_q == S_GRANT_RD) || (beat_q != 5'd0));
  assign dbg_state     = state_q;

endmodule
